// File: rtl/matmul_pkg.sv
// Shared types and helpers for the MatMul tile sequencer.
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, RD, AC, EM} state_t;

  localparam int INT8_W = 8;
  localparam int MM_W   = 16;
  localparam int SEXT_W = 64;  // widest accumulator sext16 can serve

  // Callers truncate the result to their ACC_W.
  function automatic logic [SEXT_W-1:0] sext16(input logic [MM_W-1:0] v);
    return {{(SEXT_W-MM_W){v[MM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/matmul_tile_sched_acc_bank.sv
// P-lane accumulator bank: loads or adds sign-extended MatMul lane results.
module acc_bank
  import matmul_pkg::*;
#(
  parameter int P     = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_load,
  input  logic               add_en,
  input  logic [P*MM_W-1:0]  mm_out,
  output logic [P*ACC_W-1:0] out_data
);

  if (ACC_W < MM_W || ACC_W > SEXT_W) begin : g_bad_acc_w
    $error("acc_bank: ACC_W must be in [16,64]");
  end

  for (genvar l = 0; l < P; l++) begin : g_lane
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ext;

    // lane 0 sits in the MSBs of both buses
    assign ext = ACC_W'(sext16(mm_out[(P-1-l)*MM_W +: MM_W]));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        acc <= '0;
      else if (clr_load) acc <= ext;
      else if (add_en)   acc <= acc + ext;
    end

    assign out_data[(P-1-l)*ACC_W +: ACC_W] = acc;
  end

endmodule

// File: rtl/matmul_tile_sched.sv
// Sequences x/W tile reads into the MatMul tile and accumulates P-lane output blocks.
module matmul_tile_sched
  import matmul_pkg::*;
#(
  parameter  int N       = 16,
  parameter  int P       = 16,
  parameter  int IN_DIM  = 256,
  parameter  int OUT_DIM = 32,
  parameter  int ACC_W   = 32,
  localparam int T       = IN_DIM / N,
  localparam int B       = OUT_DIM / P,
  localparam int XA_W    = (T > 1) ? $clog2(T) : 1,
  localparam int WA_W    = (T * B > 1) ? $clog2(T * B) : 1,
  localparam int BK_W    = $clog2(B) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    x_rd_en,
  output logic [XA_W-1:0]         x_addr,
  input  logic [N*INT8_W-1:0]     x_rdata,
  output logic                    w_rd_en,
  output logic [WA_W-1:0]         w_addr,
  input  logic [N*P*INT8_W-1:0]   w_rdata,
  output logic [N*INT8_W-1:0]     mm_x,
  output logic [N*P*INT8_W-1:0]   mm_w,
  input  logic [P*MM_W-1:0]       mm_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [P*ACC_W-1:0]      out_data,
  output logic [BK_W-1:0]         out_blk
);

  if (IN_DIM % N != 0) begin : g_bad_in_dim
    $error("matmul_tile_sched: IN_DIM must be a multiple of N");
  end
  if (OUT_DIM % P != 0) begin : g_bad_out_dim
    $error("matmul_tile_sched: OUT_DIM must be a multiple of P");
  end

  localparam logic [XA_W-1:0] TILE_LAST = XA_W'(T - 1);
  localparam logic [BK_W-1:0] BLK_LAST  = BK_W'(B - 1);

  state_t          state, state_nxt;
  logic [XA_W-1:0] tile, tile_nxt;
  logic [BK_W-1:0] blk, blk_nxt;
  logic            done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tile   <= '0;
      blk    <= '0;
      done   <= 1'b0;
      x_addr <= '0;
      w_addr <= '0;
    end else begin
      state <= state_nxt;
      tile  <= tile_nxt;
      blk   <= blk_nxt;
      done  <= done_nxt;
      // addresses only move when a read is about to be issued
      if (state_nxt == RD) begin
        x_addr <= tile_nxt;
        w_addr <= WA_W'(int'(blk_nxt) * T + int'(tile_nxt));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tile_nxt  = tile;
    blk_nxt   = blk;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nxt = RD;
          tile_nxt  = '0;
          blk_nxt   = '0;
        end
        RD: state_nxt = AC;
        AC: if (tile == TILE_LAST) begin
          state_nxt = EM;
        end else begin
          tile_nxt  = tile + XA_W'(1);
          state_nxt = RD;
        end
        EM: if (out_ready) begin
          if (blk == BLK_LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            blk_nxt   = blk + BK_W'(1);
            tile_nxt  = '0;
            state_nxt = RD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign x_rd_en   = (state == RD);
  assign w_rd_en   = (state == RD);
  assign out_valid = (state == EM);
  assign out_blk   = blk;
  assign mm_x      = x_rdata;
  assign mm_w      = w_rdata;

  acc_bank #(.P(P), .ACC_W(ACC_W)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_load (state == AC && tile == '0),
    .add_en   (state == AC && tile != '0),
    .mm_out   (mm_out),
    .out_data (out_data)
  );

endmodule
